adder_exhaustive_tester: RTL and testbench
==========================================

# adder_exhaustive_tester

Sequential self-test stage that sits directly upstream of the 4-bit ripple-carry adder. It drives every combination of `a`, `b` and `cin` into the adder under test, which is 512 vectors. After a programmable settle time it samples the adder's `sum` and `cout` and compares them against an internally computed golden result. It accumulates a mismatch count, the first failing vector and a sticky per-bit failure mask, so that faulty adder builds can be characterised on the board.

## Interface
Parameters:
- `SETTLE`, default 1: extra cycles each vector is held before the result is sampled; legal range 0–15.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`, input, 1: system clock; all state updates on the rising edge.
  - `rst_n`, input, 1: asynchronous active-low reset.
- Control:
  - `start`, input, 1: begin a sweep; sampled in IDLE or DONE only.
  - `abort`, input, 1: synchronous stop of a running sweep.
- Adder-under-test drive (registered):
  - `dut_a`, output, 4: operand a.
  - `dut_b`, output, 4: operand b.
  - `dut_cin`, output, 1: carry-in.
- Adder-under-test response:
  - `dut_sum`, input, 4: sum from the adder under test.
  - `dut_cout`, input, 1: carry-out from the adder under test.
- Status and results:
  - `busy`, output, 1: sweep in progress.
  - `done`, output, 1: sweep completed; level, held until the next start.
  - `pass`, output, 1: valid only when `done`=1; 1 iff `err_count`==0.
  - `err_count`, output, 10: number of mismatching vectors (0–512).
  - `first_fail_vec`, output, 9: index of the first mismatching vector; 0 if none.
  - `fail_bits`, output, 5: sticky OR of `{cout,sum[3:0]}` XOR expected over all vectors.

## Operation
- Vector index `vec[8:0]` maps as `dut_a`=`vec[3:0]`, `dut_b`=`vec[7:4]`, `dut_cin`=`vec[8]`. Sweep order is vec 0 to 511, ascending.
- Expected result is 5 bits: `{exp_cout,exp_sum}` = `dut_a` + `dut_b` + `dut_cin`, zero-extended. No truncation before the carry is taken.
- States:
  - IDLE:
    - `start` leads to RUN.
    - All result registers are cleared in the same edge.
    - `vec` is set to 0 and hold counter `h` is set to 0.
  - RUN:
    - Each vector is held while `h` counts 0..SETTLE.
    - The compare happens in the cycle where `h`==SETTLE.
    - On the edge that ends that cycle, results update, `h` is set to 0 and `vec` increments.
    - If `vec`==511 on that edge, the state goes to DONE.
  - DONE:
    - `done`=1 and `busy`=0; results are frozen.
    - `start` leads to RUN, clearing the results exactly as IDLE does.
- On a mismatch:
  - `err_count` is incremented.
  - `fail_bits` is ORed with the mismatch pattern.
  - If this is the first mismatch of the sweep, `first_fail_vec` is set to `vec`.
- `abort` in RUN:
  - Next state is IDLE, with `busy`=0 and `done`=0.
  - Partial results are retained.
  - The drive outputs keep their last value.
- `abort` in IDLE or DONE is ignored.
- `start` and `abort` asserted together in RUN: `abort` wins.
- `start` in RUN is ignored; there is no restart mid-sweep.
- `err_count` cannot overflow: its maximum value of 512 fits in 10 bits.

## Timing
- Reset values: state is IDLE, and all outputs are 0: `dut_a`, `dut_b`, `dut_cin`, `busy`, `done`, `pass`, `err_count`, `first_fail_vec`, `fail_bits`.
- Reset asserted mid-sweep: all outputs go to 0 immediately, with no clock required. After release the block is in IDLE and needs a new `start`.
- `start` is accepted at edge k:
  - From edge k, `busy`=1 and the drive outputs show vec 0.
  - Each vector occupies SETTLE+1 cycles.
  - The drive outputs change on the same edge that samples the previous vector's result.
  - Vector n is compared in the cycle ending at edge k+(n+1)(SETTLE+1).
- Completion: `done` rises and `busy` falls at edge k+512(SETTLE+1). With SETTLE=1 that is 1024 cycles.
- `pass` is registered together with `done`.
- The adder under test is combinational. Its path delay must fit within SETTLE+1 cycles minus setup.

## Test plan
- Correct RCA attached, SETTLE=1, `start` pulsed:
  - `done` at exactly +1024 cycles.
  - `pass`=1, `err_count`=0, `fail_bits`=5'b00000, `first_fail_vec`=0.
- Adder with `sum[0]` stuck at 0:
  - `err_count`=256, `first_fail_vec`=9'h001, `fail_bits`=5'b00001, `pass`=0.
- Adder with `cout` stuck at 0:
  - `err_count`=256 (120 vectors with cin=0, 136 with cin=1).
  - `first_fail_vec`=9'h01F, `fail_bits`=5'b10000.
- Sweep and restart timing:
  - SETTLE=0: `done` at +512 cycles, and every drive value is held exactly 1 cycle.
  - `start` pulsed during RUN changes nothing.
  - `start` in DONE clears the results and reruns with an identical outcome.
- `abort` at cycle 300 of a stuck-`sum[0]` run:
  - IDLE next cycle, with `busy`=0 and `done`=0.
  - `err_count`=75: vectors 0–149 compared, 75 with an odd expected sum.
  - A following `start` clears the results and sweeps fully.
- `rst_n` pulsed low mid-sweep, asynchronous and between clock edges:
  - All outputs go to 0 immediately.
  - No activity until the next `start`.

Source files
------------

// File: rtl/adder_exhaustive_tester.sv
// Purpose: exhaustive 512-vector self-test driver/checker for a 4-bit ripple-carry adder.
// Latency: each vector is held SETTLE+1 cycles; a sweep completes 512*(SETTLE+1) cycles after start.
// Backpressure: none; start is taken only in IDLE/DONE, and abort stops a running sweep on the next edge.
module adder_exhaustive_tester #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] dut_a,
    output logic [3:0] dut_b,
    output logic       dut_cin,
    input  logic [3:0] dut_sum,
    input  logic       dut_cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [9:0] err_count,
    output logic [8:0] first_fail_vec,
    output logic [4:0] fail_bits
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Hold counter is 4 bits wide, which covers the full 0..15 settle range.
    localparam logic [3:0] SETTLE_L = 4'(SETTLE);
    localparam logic [8:0] LAST_VEC = 9'd511;

    state_t     state_q, state_d;
    logic [8:0] vec_q, vec_d;          // current vector; also drives the adder directly
    logic [3:0] h_q, h_d;              // hold counter within a vector
    logic [9:0] err_q, err_d;
    logic [8:0] first_q, first_d;
    logic [4:0] bits_q, bits_d;
    logic       pass_q, pass_d;

    logic       compare_now;
    logic       last_vec;
    logic [4:0] exp_res;
    logic [4:0] obs_res;
    logic [4:0] mism;
    logic       any_mism;

    // Golden result and mismatch pattern for the vector currently driven.
    // The operands are zero-extended to 5 bits before adding so the carry is kept.
    always_comb begin
        exp_res     = {1'b0, vec_q[3:0]} + {1'b0, vec_q[7:4]} + {4'd0, vec_q[8]};
        obs_res     = {dut_cout, dut_sum};
        mism        = obs_res ^ exp_res;
        any_mism    = |mism;
        compare_now = (state_q == ST_RUN) && (h_q == SETTLE_L);
        last_vec    = (vec_q == LAST_VEC);
    end

    // Next-state, sweep sequencing and result accumulation.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        h_d     = h_q;
        err_d   = err_q;
        first_d = first_q;
        bits_d  = bits_q;
        pass_d  = pass_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A new sweep wipes every result; abort has no meaning here.
                if (start) begin
                    state_d = ST_RUN;
                    vec_d   = 9'd0;
                    h_d     = 4'd0;
                    err_d   = 10'd0;
                    first_d = 9'd0;
                    bits_d  = 5'd0;
                    pass_d  = 1'b0;
                end
            end

            ST_RUN: begin
                if (compare_now) begin
                    // The sample at the end of the hold window is always recorded,
                    // even if abort lands on the same edge.
                    if (any_mism) begin
                        err_d  = err_q + 10'd1;
                        bits_d = bits_q | mism;
                        if (err_q == 10'd0) begin
                            first_d = vec_q;
                        end
                    end
                    h_d = 4'd0;
                    if (abort) begin
                        // Drive outputs stay on the aborted vector.
                        state_d = ST_IDLE;
                        pass_d  = 1'b0;
                    end else if (last_vec) begin
                        // Drive outputs stay on vector 511 while DONE.
                        state_d = ST_DONE;
                        pass_d  = (err_d == 10'd0);
                    end else begin
                        vec_d = vec_q + 9'd1;
                    end
                end else begin
                    h_d = h_q + 4'd1;
                    if (abort) begin
                        state_d = ST_IDLE;
                        pass_d  = 1'b0;
                    end
                end
                // start is deliberately ignored while running.
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset clears everything without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= 9'd0;
            h_q     <= 4'd0;
            err_q   <= 10'd0;
            first_q <= 9'd0;
            bits_q  <= 5'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            h_q     <= h_d;
            err_q   <= err_d;
            first_q <= first_d;
            bits_q  <= bits_d;
            pass_q  <= pass_d;
        end
    end

    assign dut_a          = vec_q[3:0];
    assign dut_b          = vec_q[7:4];
    assign dut_cin        = vec_q[8];
    assign busy           = (state_q == ST_RUN);
    assign done           = (state_q == ST_DONE);
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail_vec = first_q;
    assign fail_bits      = bits_q;

endmodule

// File: tb/tb_adder_exhaustive_tester.sv
// Purpose: directed self-checking bench for adder_exhaustive_tester with behavioural adders.
// Latency: expects done 512*(SETTLE+1) cycles after start; checks drive timing every cycle.
// Backpressure: none; start/abort are driven as single-cycle pulses.
module tb_adder_exhaustive_tester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_s, abort_s;
    logic sel;                 // 0: SETTLE=1 instance, 1: SETTLE=0 instance
    int   mode;                // 0 good adder, 1 sum[0] stuck 0, 2 cout stuck 0

    logic       start0, abort0, start1, abort1;
    logic [3:0] a0, b0, s0, a1, b1, s1;
    logic       ci0, co0, ci1, co1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [9:0] err0, err1;
    logic [8:0] ff0, ff1;
    logic [4:0] fb0, fb1;

    assign start0 = start_s & ~sel;
    assign abort0 = abort_s & ~sel;
    assign start1 = start_s & sel;
    assign abort1 = abort_s & sel;

    // Behavioural adder under test with an optional stuck-at fault.
    function automatic logic [4:0] fault_add(input int m, input logic [3:0] a,
                                             input logic [3:0] b, input logic c);
        logic [4:0] r;
        r = 5'(a) + 5'(b) + 5'(c);
        if (m == 1) r[0] = 1'b0;
        if (m == 2) r[4] = 1'b0;
        return r;
    endfunction

    assign {co0, s0} = fault_add(mode, a0, b0, ci0);
    assign {co1, s1} = fault_add(mode, a1, b1, ci1);

    adder_exhaustive_tester #(.SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .dut_a(a0), .dut_b(b0), .dut_cin(ci0), .dut_sum(s0), .dut_cout(co0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_fail_vec(ff0), .fail_bits(fb0)
    );

    adder_exhaustive_tester #(.SETTLE(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .dut_a(a1), .dut_b(b1), .dut_cin(ci1), .dut_sum(s1), .dut_cout(co1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail_vec(ff1), .fail_bits(fb1)
    );

    // Observed signals of the selected instance.
    logic [8:0] o_vec;
    logic       o_busy, o_done, o_pass;
    logic [9:0] o_err;
    logic [8:0] o_ff;
    logic [4:0] o_fb;
    assign o_vec  = sel ? {ci1, b1, a1} : {ci0, b0, a0};
    assign o_busy = sel ? busy1 : busy0;
    assign o_done = sel ? done1 : done0;
    assign o_pass = sel ? pass1 : pass0;
    assign o_err  = sel ? err1  : err0;
    assign o_ff   = sel ? ff1   : ff0;
    assign o_fb   = sel ? fb1   : fb0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int err;
        int first;
        int bits;
        int pass;
        int cycles;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference accumulation over the first n vectors of a sweep.
    function automatic exp_t model(input int m, input int n, input int cyc);
        exp_t e;
        logic [8:0] v;
        logic [4:0] g, x;
        e.err = 0; e.first = 0; e.bits = 0; e.cycles = cyc;
        for (int i = 0; i < n; i++) begin
            v = 9'(i);
            g = 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]);
            x = g ^ fault_add(m, v[3:0], v[7:4], v[8]);
            if (x != 5'd0) begin
                if (e.err == 0) e.first = i;
                e.err++;
                e.bits |= int'(x);
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        return e;
    endfunction

    // One sweep on the selected instance; abort_at>0 aborts at edge k+abort_at.
    task automatic sweep(input string name, input logic s, input int m,
                         input int abort_at, input bit mid_start);
        int   st, total, c, done_at, bad;
        exp_t e;
        sel   = s;
        mode  = m;
        st    = s ? 0 : 1;
        total = 512 * (st + 1);
        if (abort_at > 0) sb_q.push_back(model(m, abort_at / (st + 1), abort_at));
        else              sb_q.push_back(model(m, 512, total));

        @(negedge clk); start_s = 1'b1;
        @(posedge clk); #1; start_s = 1'b0;
        check({name, ":busy_at_start"}, o_busy, 1);
        check({name, ":err_cleared"}, o_err, 0);
        c = 0; done_at = -1; bad = 0;
        while (c < total + 64) begin
            if (c < total && o_vec !== 9'(c / (st + 1))) bad++;
            if (abort_at > 0 && c == abort_at - 1) abort_s = 1'b1;
            if (mid_start && c == 100) start_s = 1'b1;
            @(posedge clk); #1;
            abort_s = 1'b0; start_s = 1'b0;
            c++;
            if (abort_at > 0 && c == abort_at) break;
            if (o_done) begin done_at = c; break; end
        end
        check({name, ":drive_seq"}, bad, 0);
        e = sb_q.pop_front();
        if (abort_at > 0) begin
            check({name, ":abort_busy"}, o_busy, 0);
            check({name, ":abort_done"}, o_done, 0);
            check({name, ":abort_drive_held"}, o_vec, (abort_at - 1) / (st + 1));
        end else begin
            check({name, ":done_cycle"}, done_at, e.cycles);
            check({name, ":busy_low"}, o_busy, 0);
            check({name, ":pass"}, o_pass, e.pass);
        end
        check({name, ":err_count"}, o_err, e.err);
        check({name, ":first_fail"}, o_ff, e.first);
        check({name, ":fail_bits"}, o_fb, e.bits);
    endtask

    initial begin
        rst_n = 1'b0; start_s = 1'b0; abort_s = 1'b0; sel = 1'b0; mode = 0;
        #23;
        check("reset_outputs_s1", {a0, b0, ci0, busy0, done0, pass0, err0, ff0, fb0}, 0);
        check("reset_outputs_s0", {a1, b1, ci1, busy1, done1, pass1, err1, ff1, fb1}, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_without_start", {busy0, done0}, 0);

        // Good adder, with a start pulse mid-sweep that must be ignored.
        sweep("good_s1", 1'b0, 0, 0, 1'b1);
        // Stuck sum[0], then restart from DONE with an identical outcome.
        sweep("sum0_s1", 1'b0, 1, 0, 1'b0);
        sweep("sum0_rerun_s1", 1'b0, 1, 0, 1'b0);
        // Stuck carry-out.
        sweep("cout_s1", 1'b0, 2, 0, 1'b0);
        // Abort at cycle 300 of a stuck-sum[0] run.
        sweep("abort_s1", 1'b0, 1, 300, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_results_retained", o_err, 75);
        abort_s = 1'b1;
        @(posedge clk); #1; abort_s = 1'b0;
        check("abort_in_idle_ignored", {o_busy, o_done}, 0);
        sweep("after_abort_s1", 1'b0, 1, 0, 1'b0);

        // Asynchronous reset between clock edges in the middle of a sweep.
        sel = 1'b0; mode = 1;
        @(negedge clk); start_s = 1'b1;
        @(posedge clk); #1; start_s = 1'b0;
        repeat (60) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {a0, b0, ci0, busy0, done0, pass0, err0, ff0, fb0}, 0);
        #2;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("no_activity_after_reset", {a0, b0, ci0, busy0, done0, err0}, 0);
        sweep("after_reset_s1", 1'b0, 1, 0, 1'b0);

        // SETTLE=0 instance: one cycle per vector.
        sweep("good_s0", 1'b1, 0, 0, 1'b0);
        sweep("cout_s0", 1'b1, 2, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
